// File: rtl/cpu_core_mc_if.sv
// Memory-side bundle of cpu_core_mc: instruction fetch port and data port.
// The core drives requests through the master modport; memories use slave.
interface cpu_core_mc_if #(
  parameter int DATA_W = 8
) ();
  logic              imem_read;
  logic [31:0]       imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_busywait;
  logic              dmem_read;
  logic              dmem_write;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_busywait;

  modport master (
    output imem_read, imem_addr, dmem_read, dmem_write, dmem_addr, dmem_wdata,
    input  imem_rdata, imem_busywait, dmem_rdata, dmem_busywait
  );

  modport slave (
    input  imem_read, imem_addr, dmem_read, dmem_write, dmem_addr, dmem_wdata,
    output imem_rdata, imem_busywait, dmem_rdata, dmem_busywait
  );
endinterface

// File: rtl/cpu_core_mc.sv
// cpu_core_mc: multi-cycle core, FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// All bus requests come from registers. Register file is written only in WB.
// Optional feature: define CPU_CORE_MC_MUL_EN to add opcode 15 (mult, 2-cycle
// EXEC); without it opcode 15 is an illegal opcode.
module cpu_core_mc #(
  parameter int DATA_W = 8,
  parameter int REG_N  = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  cpu_core_mc_if.master bus,
  output logic [31:0]  pc,
  output logic [2:0]   state,
  output logic         illegal
);
  localparam int RI = $clog2(REG_N);
  localparam logic [7:0] DW8 = 8'(DATA_W);

  localparam logic [7:0] OP_LOADI = 8'd0,  OP_MOV = 8'd1,  OP_ADD = 8'd2,
                         OP_SUB   = 8'd3,  OP_AND = 8'd4,  OP_OR  = 8'd5,
                         OP_J     = 8'd6,  OP_BEQ = 8'd7,  OP_LWD = 8'd8,
                         OP_LWI   = 8'd9,  OP_SWD = 8'd10, OP_SWI = 8'd11,
                         OP_BNE   = 8'd12, OP_SLL = 8'd13, OP_SRL = 8'd14;
`ifdef CPU_CORE_MC_MUL_EN
  localparam logic [7:0] OP_MUL = 8'd15;
`endif

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4
  } st_t;

  st_t                          st;
  logic [31:0]                  ir;
  logic [REG_N-1:0][DATA_W-1:0] regs;
  logic [DATA_W-1:0]            op_a, op_b, res, alu;
  logic                         imem_read_q, dmem_read_q, dmem_write_q;
  logic [DATA_W-1:0]            dmem_addr_q, dmem_wdata_q;
  logic                         legal;
`ifdef CPU_CORE_MC_MUL_EN
  logic                         mul_ph;
`endif

  // instruction fields
  logic [7:0]        opc, shamt;
  logic [RI-1:0]     rd, rs1, rs2;
  logic [DATA_W-1:0] imm_x;
  logic [31:0]       pc4, br_tgt;
  logic              is_ld, is_st, is_br, take;
  wire               unused_ir = ^ir[15:8];

  assign opc    = ir[31:24];
  assign rd     = ir[16 +: RI];
  assign rs1    = ir[8 +: RI];
  assign rs2    = ir[0 +: RI];
  assign shamt  = ir[7:0];
  assign imm_x  = DATA_W'($signed(ir[7:0]));
  assign pc4    = pc + 32'd4;
  assign br_tgt = pc4 + {{22{ir[23]}}, ir[23:16], 2'b00};
  assign is_ld  = (opc == OP_LWD) || (opc == OP_LWI);
  assign is_st  = (opc == OP_SWD) || (opc == OP_SWI);
  assign is_br  = (opc == OP_J) || (opc == OP_BEQ) || (opc == OP_BNE);
  assign take   = (opc == OP_J) || ((opc == OP_BEQ) && (op_a == op_b)) ||
                  ((opc == OP_BNE) && (op_a != op_b));

  assign state             = st;
  assign bus.imem_read     = imem_read_q;
  assign bus.imem_addr     = pc;
  assign bus.dmem_read     = dmem_read_q;
  assign bus.dmem_write    = dmem_write_q;
  assign bus.dmem_addr     = dmem_addr_q;
  assign bus.dmem_wdata    = dmem_wdata_q;

  // ALU result and opcode legality from the latched instruction
  always_comb begin
    alu   = '0;
    legal = 1'b1;
    case (opc)
      OP_LOADI: alu = imm_x;
      OP_MOV:   alu = op_a;
      OP_ADD:   alu = op_a + op_b;
      OP_SUB:   alu = op_a - op_b;
      OP_AND:   alu = op_a & op_b;
      OP_OR:    alu = op_a | op_b;
      OP_SLL:   alu = (shamt >= DW8) ? '0 : (op_a << shamt);
      OP_SRL:   alu = (shamt >= DW8) ? '0 : (op_a >> shamt);
      OP_J, OP_BEQ, OP_BNE, OP_LWD, OP_LWI, OP_SWD, OP_SWI: alu = '0;
`ifdef CPU_CORE_MC_MUL_EN
      OP_MUL:   alu = op_a * op_b;
`endif
      default:  legal = 1'b0;
    endcase
  end

  // control FSM, datapath registers, register file and bus requests
  always_ff @(posedge CLK) begin
    if (RESET) begin
      st           <= FETCH;
      pc           <= '0;
      ir           <= '0;
      regs         <= '0;
      op_a         <= '0;
      op_b         <= '0;
      res          <= '0;
      illegal      <= 1'b0;
      imem_read_q  <= 1'b0;
      dmem_read_q  <= 1'b0;
      dmem_write_q <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
`ifdef CPU_CORE_MC_MUL_EN
      mul_ph       <= 1'b0;
`endif
    end else begin
      case (st)
        FETCH: begin
          // first cycle out of reset only raises the request
          if (!imem_read_q) imem_read_q <= 1'b1;
          else if (!bus.imem_busywait) begin
            ir          <= bus.imem_rdata;
            imem_read_q <= 1'b0;
            st          <= DECODE;
          end
        end
        DECODE: begin
          op_a <= regs[rs1];
          op_b <= regs[rs2];
          st   <= EXEC;
        end
        EXEC: begin
          res <= alu;
          if (!legal) begin
            illegal     <= 1'b1;
            pc          <= pc4;
            imem_read_q <= 1'b1;
            st          <= FETCH;
          end else if (is_ld || is_st) begin
            pc           <= pc4;
            dmem_addr_q  <= ((opc == OP_LWD) || (opc == OP_SWD)) ? op_b : imm_x;
            dmem_wdata_q <= op_a;
            dmem_read_q  <= is_ld;
            dmem_write_q <= is_st;
            st           <= MEM;
          end else if (is_br) begin
            pc          <= take ? br_tgt : pc4;
            imem_read_q <= 1'b1;
            st          <= FETCH;
          end
`ifdef CPU_CORE_MC_MUL_EN
          else if ((opc == OP_MUL) && !mul_ph) mul_ph <= 1'b1;
`endif
          else begin
            pc <= pc4;
            st <= WB;
          end
        end
        MEM: begin
          // request holds until the edge that sees busywait low
          if (!bus.dmem_busywait) begin
            dmem_read_q  <= 1'b0;
            dmem_write_q <= 1'b0;
            if (dmem_read_q) begin
              res <= bus.dmem_rdata;
              st  <= WB;
            end else begin
              imem_read_q <= 1'b1;
              st          <= FETCH;
            end
          end
        end
        WB: begin
          regs[rd]    <= res;
          imem_read_q <= 1'b1;
          st          <= FETCH;
`ifdef CPU_CORE_MC_MUL_EN
          mul_ph      <= 1'b0;
`endif
        end
        default: st <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_core_mc.sv
// Directed bench for cpu_core_mc: 8-bit core with instruction/data memory
// models plus a 16-bit/16-register core for shift boundaries.
module tb_cpu_core_mc;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  cpu_core_mc_if #(.DATA_W(8))  bus_a ();
  cpu_core_mc_if #(.DATA_W(16)) bus_b ();
  logic [31:0] pc_a, pc_b;
  logic [2:0]  st_a, st_b;
  logic        ill_a, ill_b;

  cpu_core_mc #(.DATA_W(8), .REG_N(8)) dut_a (
    .CLK(CLK), .RESET(RESET), .bus(bus_a), .pc(pc_a), .state(st_a), .illegal(ill_a));
  cpu_core_mc #(.DATA_W(16), .REG_N(16)) dut_b (
    .CLK(CLK), .RESET(RESET), .bus(bus_b), .pc(pc_b), .state(st_b), .illegal(ill_b));

  // memories
  logic [31:0] imem_a [64];
  logic [31:0] imem_b [64];
  logic [7:0]  dmem   [256];
  int          dbusy_n = 0;
  int          dcnt    = 0;

  assign bus_a.imem_rdata    = imem_a[bus_a.imem_addr[7:2]];
  assign bus_a.imem_busywait = 1'b0;
  assign bus_a.dmem_rdata    = dmem[bus_a.dmem_addr];
  assign bus_a.dmem_busywait = (bus_a.dmem_read | bus_a.dmem_write) && (dcnt < dbusy_n);
  assign bus_b.imem_rdata    = imem_b[bus_b.imem_addr[7:2]];
  assign bus_b.imem_busywait = 1'b0;
  assign bus_b.dmem_rdata    = '0;
  assign bus_b.dmem_busywait = 1'b0;

  always @(posedge CLK) begin
    if (RESET) begin
      dcnt <= 0;
      for (int i = 0; i < 256; i++) dmem[i] <= 8'h00;
    end else if (bus_a.dmem_read | bus_a.dmem_write) begin
      if (dcnt < dbusy_n) dcnt <= dcnt + 1;
      else begin
        dcnt <= 0;
        if (bus_a.dmem_write) dmem[bus_a.dmem_addr] <= bus_a.dmem_wdata;
      end
    end else dcnt <= 0;
  end

  // write-request monitor: cycles with dmem_write high, and cycles where it
  // was high with anything but the expected store address/data
  int wr_cyc = 0, wr_bad = 0;
  always @(negedge CLK) begin
    if (bus_a.dmem_write) begin
      wr_cyc <= wr_cyc + 1;
      if (bus_a.dmem_addr != 8'h10 || bus_a.dmem_wdata != 8'h5A) wr_bad <= wr_bad + 1;
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] c);
    return {op, a, b, c};
  endfunction

  localparam logic [31:0] JSELF = {8'd6, 8'hFF, 8'd0, 8'd0};

  task automatic clear_a();
    for (int i = 0; i < 64; i++) imem_a[i] = JSELF;
  endtask

  // reset pulse; leaves the bench at the first cycle of the fetch at pc 0
  task automatic do_reset(input bit chk_rst);
    RESET = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    if (chk_rst) begin
      chk("rst_pc", pc_a, 32'd0);
      chk("rst_state", {29'd0, st_a}, 32'd0);
      chk("rst_imem_read", {31'd0, bus_a.imem_read}, 32'd0);
      chk("rst_dmem_read", {31'd0, bus_a.dmem_read}, 32'd0);
      chk("rst_dmem_write", {31'd0, bus_a.dmem_write}, 32'd0);
      chk("rst_illegal", {31'd0, ill_a}, 32'd0);
    end
    RESET = 1'b0;
    @(negedge CLK);
    chk("first_fetch", {31'd0, bus_a.imem_read}, 32'd1);
  endtask

  // cycles until the next fetch request rises; -1 on timeout
  task automatic wait_fetch(output int cyc);
    logic prev;
    prev = bus_a.imem_read;
    cyc  = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      cyc++;
      if (bus_a.imem_read && !prev) return;
      prev = bus_a.imem_read;
    end
    cyc = -1;
  endtask

  initial begin
    int c, w0, b0, nz, k;
    for (int i = 0; i < 64; i++) imem_b[i] = JSELF;
    imem_b[0] = ins(8'd0, 8'd15, 8'd0, 8'hFF);    // loadi r15,-1
    imem_b[1] = ins(8'd13, 8'd14, 8'd15, 8'd4);   // sll r14,r15,4
    imem_b[2] = ins(8'd14, 8'd13, 8'd15, 8'd16);  // srl r13,r15,16

    // arithmetic sequence
    clear_a();
    imem_a[0] = ins(8'd0, 8'd1, 8'd0, 8'd5);
    imem_a[1] = ins(8'd0, 8'd2, 8'd0, 8'd3);
    imem_a[2] = ins(8'd2, 8'd3, 8'd1, 8'd2);
    imem_a[3] = ins(8'd3, 8'd4, 8'd1, 8'd2);
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_fetch(c);
      chk($sformatf("alu_lat%0d", i), c, 32'd4);
      chk($sformatf("alu_pc%0d", i), pc_a, 32'(4 * (i + 1)));
    end
    chk("r1", {24'd0, dut_a.regs[1]}, 32'd5);
    chk("r2", {24'd0, dut_a.regs[2]}, 32'd3);
    chk("r3_add", {24'd0, dut_a.regs[3]}, 32'd8);
    chk("r4_sub", {24'd0, dut_a.regs[4]}, 32'd2);

    // 16-bit core has been running the same time from the same reset
    chk("b_r15", {16'd0, dut_b.regs[15]}, 32'hFFFF);
    chk("b_sll", {16'd0, dut_b.regs[14]}, 32'hFFF0);
    chk("b_srl16", {16'd0, dut_b.regs[13]}, 32'h0);
    chk("b_pc", pc_b, 32'd12);

    // beq taken backwards, then bne not taken
    clear_a();
    imem_a[0] = ins(8'd0, 8'd1, 8'd0, 8'd7);
    imem_a[1] = ins(8'd0, 8'd2, 8'd0, 8'd7);
    imem_a[2] = ins(8'd7, 8'hFE, 8'd1, 8'd2);
    do_reset(1'b0);
    wait_fetch(c); wait_fetch(c); wait_fetch(c);
    chk("beq_lat", c, 32'd3);
    chk("beq_pc", pc_a, 32'd4);
    imem_a[2] = ins(8'd12, 8'hFE, 8'd1, 8'd2);
    do_reset(1'b0);
    wait_fetch(c); wait_fetch(c); wait_fetch(c);
    chk("bne_lat", c, 32'd3);
    chk("bne_pc", pc_a, 32'd12);

    // store with 3 wait cycles, then load it back
    clear_a();
    imem_a[0] = ins(8'd0, 8'd1, 8'd0, 8'h5A);
    imem_a[1] = ins(8'd11, 8'd0, 8'd1, 8'h10);
    imem_a[2] = ins(8'd9, 8'd5, 8'd0, 8'h10);
    dbusy_n = 3;
    do_reset(1'b0);
    wait_fetch(c);
    w0 = wr_cyc; b0 = wr_bad;
    wait_fetch(c);
    chk("swi_lat", c, 32'd7);
    chk("swi_req_cycles", wr_cyc - w0, 32'd4);
    chk("swi_req_stable", wr_bad - b0, 32'd0);
    chk("swi_mem", {24'd0, dmem[8'h10]}, 32'h5A);
    chk("swi_req_low", {31'd0, bus_a.dmem_write}, 32'd0);
    wait_fetch(c);
    chk("lwi_lat", c, 32'd8);
    chk("lwi_r5", {24'd0, dut_a.regs[5]}, 32'h5A);
    dbusy_n = 0;

    // illegal opcode, then opcode 15
    clear_a();
    imem_a[0] = ins(8'd0, 8'd1, 8'd0, 8'd12);
    imem_a[1] = ins(8'd0, 8'd2, 8'd0, 8'd11);
    imem_a[2] = ins(8'hFF, 8'd1, 8'd1, 8'd2);
    imem_a[3] = ins(8'd15, 8'd3, 8'd1, 8'd2);
    do_reset(1'b0);
    wait_fetch(c); wait_fetch(c);
    chk("ill_before", {31'd0, ill_a}, 32'd0);
    wait_fetch(c);
    chk("ill_lat", c, 32'd3);
    chk("ill_flag", {31'd0, ill_a}, 32'd1);
    chk("ill_pc", pc_a, 32'd12);
    chk("ill_r1", {24'd0, dut_a.regs[1]}, 32'd12);
    wait_fetch(c);
`ifdef CPU_CORE_MC_MUL_EN
    chk("mul_lat", c, 32'd5);
    chk("mul_r3", {24'd0, dut_a.regs[3]}, 32'h84);
`else
    chk("op15_lat", c, 32'd3);
    chk("op15_r3", {24'd0, dut_a.regs[3]}, 32'h0);
`endif
    chk("ill_sticky", {31'd0, ill_a}, 32'd1);

    // reset while a load is stalled in MEM
    clear_a();
    imem_a[0] = ins(8'd0, 8'd1, 8'd0, 8'h5A);
    imem_a[1] = ins(8'd9, 8'd5, 8'd0, 8'h10);
    dbusy_n = 1000;
    do_reset(1'b0);
    wait_fetch(c);
    k = 0;
    while (st_a != 3'd3 && k < 20) begin
      @(negedge CLK);
      k++;
    end
    @(negedge CLK);
    chk("stall_state", {29'd0, st_a}, 32'd3);
    chk("stall_read", {31'd0, bus_a.dmem_read}, 32'd1);
    chk("stall_addr", {24'd0, bus_a.dmem_addr}, 32'h10);
    RESET = 1'b1;
    @(negedge CLK);
    chk("mrst_read", {31'd0, bus_a.dmem_read}, 32'd0);
    chk("mrst_pc", pc_a, 32'd0);
    chk("mrst_state", {29'd0, st_a}, 32'd0);
    nz = 0;
    for (int i = 0; i < 8; i++) if (dut_a.regs[i] != 8'd0) nz++;
    chk("mrst_regs_nonzero", nz, 32'd0);
    RESET = 1'b0;
    dbusy_n = 0;
    @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cpu_core_mc.md
CPU_CORE_MC -- requirements
Module: cpu_core_mc

Interface
REQ-001 Parameter DATA_W, default 8: datapath, register and data-address width; legal values 8, 16, 32.
REQ-002 Parameter REG_N, default 8: register count; power of two, 2..32; register index is log2(REG_N) LSBs of the instruction field.
REQ-003 CLK  in  1  clock; all state changes on rising edge.
REQ-004 RESET  in  1  reset; synchronous, active-high (clock CLK).
REQ-005 imem_read  out  1  instruction fetch request; imem_addr  out  32  byte address (=pc).
REQ-006 imem_rdata  in  32  instruction word; imem_busywait  in  1  high = fetch not complete.
REQ-007 dmem_read / dmem_write  out  1 each  data request, never both high.
REQ-008 dmem_addr  out  DATA_W; dmem_wdata  out  DATA_W; dmem_rdata  in  DATA_W; dmem_busywait  in  1.
REQ-009 pc  out  32  current instruction address; state  out  3  FSM state code; illegal  out  1  sticky illegal-opcode flag.

Function
REQ-010 Instruction fields: [31:24] opcode, [23:16] rd or offset, [15:8] rs1, [7:0] rs2 or imm8; imm8 sign-extended to DATA_W.
REQ-011 Opcodes: 0 loadi, 1 mov, 2 add, 3 sub, 4 and, 5 or, 6 j, 7 beq, 8 lwd, 9 lwi, 10 swd, 11 swi, 12 bne, 13 sll, 14 srl; others per REQ-026.
REQ-012 FSM states/codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
REQ-013 FETCH: imem_read=1, imem_addr=pc; on edge with imem_busywait=0 latch IR, go DECODE; else stay.
REQ-014 DECODE: read rs1/rs2 into operand registers; go EXEC (1 cycle).
REQ-015 EXEC: compute ALU result (mod 2^DATA_W); pc<=pc+4 or branch target; lwd/lwi/swd/swi -> MEM; j/beq/bne -> FETCH; others -> WB.
REQ-016 Branch target = pc+4 + (sign-extended 8-bit offset << 2), 32-bit wrap-around; beq taken when rs1==rs2, bne when rs1!=rs2.
REQ-017 lwd/swd address = rs2 value; lwi/swi address = imm8 truncated/extended to DATA_W; store data = rs1.
REQ-018 MEM: dmem request high from MEM entry until the edge sampling dmem_busywait=0; request low the following cycle; load -> WB with dmem_rdata latched, store -> FETCH.
REQ-019 WB: write rd with ALU result or load data; go FETCH; register file written only in WB.
REQ-020 sll/srl: shift rs1 by imm8 zero-filled; shift amount >= DATA_W yields 0.
REQ-021 Latency with zero-wait memory: ALU/loadi/mov 4 cycles, j/branch 3, store 4, load 5; each busywait cycle adds one.
REQ-022 Request outputs are registered; imem and dmem requests never high simultaneously.
REQ-023 Busywait held high indefinitely: core stalls in FETCH or MEM with request and address stable.
REQ-024 Writes to rd in WB and reads in DECODE never overlap; no forwarding needed.
REQ-025 Register indices >= REG_N impossible by truncation; rd index uses [16+log2(REG_N)-1:16].
REQ-026 Undefined opcode: set illegal, treat as NOP (pc+4, no write, no memory access), -> FETCH from EXEC.

Reset
REQ-027 On RESET edge: pc=0, state=FETCH, all registers 0, IR=0, illegal=0, imem_read/dmem_read/dmem_write=0.
REQ-028 RESET mid-access (FETCH or MEM): requests deassert the cycle after the reset edge; pending data discarded; no register write.
REQ-029 First fetch request asserted in the first cycle after RESET deasserts.

Configuration
REQ-030 Macro CPU_CORE_MC_MUL_EN: when defined, opcode 15 mult: rd = low DATA_W bits of rs1*rs2, EXEC extended to 2 cycles (total 5).
REQ-031 Without CPU_CORE_MC_MUL_EN, opcode 15 is undefined and handled per REQ-026; no multiplier logic instantiated.

Verification
REQ-032 Reset then loadi r1,5; loadi r2,3; add r3,r1,r2; sub r4,r1,r2 -> r3=8, r4=2, each instruction 4 cycles with zero-wait memory.
REQ-033 r1=r2=7, beq offset -2 at pc 8 -> pc=4 next fetch; bne same operands -> pc=12.
REQ-034 swi r1(=0x5A) to 0x10 with dmem_busywait high 3 cycles, then lwi r5,0x10 -> r5=0x5A; store takes 7 cycles, request stable throughout.
REQ-035 Opcode 0xFF fetched -> illegal=1, registers unchanged, pc advances by 4; opcode 15 with macro defined and r1=12,r2=11 (DATA_W=8) -> rd=0x84.
REQ-036 RESET asserted during MEM with busywait high -> next cycle dmem_read=0, pc=0, state=0, all registers 0.
REQ-037 DATA_W=16, REG_N=16: loadi r15,-1; sll r14,r15,4 -> r14=0xFFF0; srl r13,r15,16 -> r13=0.
